// File: rtl/pio_edge_event_scheduler.sv
// pio_edge_event_scheduler: polls an 8-bit edge-capture PIO over Avalon-MM and queues timestamped edge events
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   enable                  allows a new poll to start (sampled in IDLE only)
//   avm_*                   Avalon-MM master to the PIO (0 = level data, 3 = edge capture, W1C)
//   ev_valid/ev_ready/ev_data  show-ahead event stream {timestamp, edge_mask, level}
//   ev_count                event FIFO occupancy
//   overflow/overflow_clr   sticky dropped-event flag and its clear
//   busy                    a polling sequence is in progress
module pio_edge_event_scheduler #(
    parameter int POLL_DIV   = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    output logic [1:0]                    avm_address,
    output logic                          avm_chipselect,
    output logic                          avm_write_n,
    output logic [31:0]                   avm_writedata,
    input  logic [31:0]                   avm_readdata,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [31:0]                   ev_data,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic                          busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, RD_EDGE, WAIT_EDGE, RD_DATA, WAIT_DATA, WR_CLR, PUSH} state_t;

    state_t              state;
    logic [15:0]         timer;
    logic [TS_WIDTH-1:0] timestamp;
    logic [TS_WIDTH-1:0] ts;
    logic [7:0]          mask;
    logic [7:0]          level;
    logic [31:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                pop;
    logic                push_ok;
    logic                push_drop;
    logic                unused_rd;

    assign unused_rd = ^avm_readdata[31:8];

    assign ev_valid  = ev_count != '0;
    assign ev_data   = ev_valid ? mem[rd_ptr] : 32'h0;
    assign pop       = ev_valid && ev_ready;
    // A same-cycle pop frees the slot the push needs, so a full FIFO still accepts.
    assign push_ok   = state == PUSH && (ev_count != CW'(FIFO_DEPTH) || pop);
    assign push_drop = state == PUSH && !push_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) timestamp <= '0;
        else timestamp <= timestamp + 1'b1;
    end

    // Bus outputs are assigned on entry to the state that presents them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            timer          <= 16'd0;
            avm_address    <= 2'd0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= 32'h0;
            busy           <= 1'b0;
            ts             <= '0;
            mask           <= 8'h0;
            level          <= 8'h0;
        end else begin
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            case (state)
                IDLE: begin
                    if (timer != 16'(POLL_DIV - 1)) timer <= timer + 16'd1;
                    else if (enable) begin
                        timer          <= 16'd0;
                        state          <= RD_EDGE;
                        avm_address    <= 2'd3;
                        avm_chipselect <= 1'b1;
                        busy           <= 1'b1;
                    end
                end
                RD_EDGE: state <= WAIT_EDGE;
                WAIT_EDGE: begin
                    mask <= avm_readdata[7:0];
                    ts   <= timestamp;
                    if (avm_readdata[7:0] == 8'h0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state          <= RD_DATA;
                        avm_address    <= 2'd0;
                        avm_chipselect <= 1'b1;
                    end
                end
                RD_DATA: state <= WAIT_DATA;
                WAIT_DATA: begin
                    level          <= avm_readdata[7:0];
                    state          <= WR_CLR;
                    avm_address    <= 2'd3;
                    avm_chipselect <= 1'b1;
                    avm_write_n    <= 1'b0;
                    avm_writedata  <= {24'h0, mask};
                end
                WR_CLR: state <= PUSH;
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {ts, mask, level};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ev_count <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            ev_count <= ev_count + CW'(push_ok) - CW'(pop);
            // A drop in the same cycle as a clear keeps the flag set.
            overflow <= push_drop || (overflow && !overflow_clr);
        end
    end
endmodule

// File: doc/pio_edge_event_scheduler.md
Name: pio_edge_event_scheduler

Overview:
Avalon-MM master that sequences an 8-bit edge-capture PIO slave. Address map: 0 = level data, 3 = edge capture, write-1-to-clear. The block periodically polls the edge-capture register. When edges are pending, it reads the level data, clears exactly the bits it saw, and pushes a timestamped event record into an internal FIFO for a streaming consumer. It sits between the PIO slave and the trigger/event logic, so no software polling is needed.

Parameters:
POLL_DIV, 16, clock cycles spent in IDLE between polling sequences (legal 1..65535)
FIFO_DEPTH, 8, event FIFO entries; power of two, 2..64
TS_WIDTH, 16, timestamp counter width; fixed 16 for the 32-bit record

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  1 = polling allowed; sampled only in IDLE
avm_address  out  2  PIO register address
avm_chipselect  out  1  PIO chip select
avm_write_n  out  1  PIO write strobe, active low
avm_writedata  out  32  PIO write data (clear mask)
avm_readdata  in  32  PIO read data; registered, valid 1 cycle after address
ev_valid  out  1  FIFO not empty
ev_ready  in  1  consumer accepts head entry
ev_data  out  32  head record {timestamp[31:16], edge_mask[15:8], level[7:0]}
ev_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: an event was dropped because the FIFO was full
overflow_clr  in  1  clears overflow
busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: single clock. Reset is asynchronous on reset_n low and clears all state.
- Reset values:
  - avm_address=0, avm_chipselect=0, avm_write_n=1, avm_writedata=0.
  - ev_valid=0, ev_data=0, ev_count=0, overflow=0, busy=0.
  - FSM in IDLE, poll timer=0, timestamp=0, FIFO emptied.
- Bus outputs are registered from state. avm_write_n=1 in every state except WR_CLR.
- Timestamp: free-running TS_WIDTH counter, +1 per clk, wraps 0xFFFF->0x0000.
- FSM:
  - IDLE: timer counts up. When timer==POLL_DIV-1 and enable=1 -> RD_EDGE, timer cleared. If enable=0, the timer holds at POLL_DIV-1.
  - RD_EDGE (1 cyc): address=3, chipselect=1 -> WAIT_EDGE.
  - WAIT_EDGE (1 cyc): chipselect=0. Latch mask=avm_readdata[7:0] and ts=timestamp. If mask==0 -> IDLE, else -> RD_DATA.
  - RD_DATA (1 cyc): address=0, chipselect=1 -> WAIT_DATA.
  - WAIT_DATA (1 cyc): latch level=avm_readdata[7:0] -> WR_CLR.
  - WR_CLR (1 cyc): address=3, chipselect=1, write_n=0, writedata={24'b0,mask} -> PUSH.
  - PUSH (1 cyc): write {ts,mask,level} into the FIFO, or drop it (see FIFO rules) -> IDLE.
- Sequence latency: an empty poll takes 2 cycles; an event sequence takes 6 cycles from RD_EDGE to PUSH.
- enable deasserted mid-sequence: the sequence completes. No new poll starts.
- Only mask bits are cleared. Edges on other bits arriving during the sequence stay captured for the next poll.
- A same-bit edge coinciding with the WR_CLR cycle is lost: the slave gives the clear priority. This is an accepted limitation and is not flagged.
- FIFO: show-ahead, so ev_data = head whenever ev_valid=1. Pop on ev_valid&&ev_ready.
- Push in PUSH succeeds if count<FIFO_DEPTH or a pop occurs in the same cycle. Simultaneous push+pop when full keeps count=FIFO_DEPTH.
- Dropped push: set overflow=1. The FIFO is unchanged.
- overflow_clr and a new drop in the same cycle: overflow stays 1 (set wins).
- Pointers wrap modulo FIFO_DEPTH.
- Reset mid-sequence: bus outputs drop to idle values immediately. Any partial event is discarded and no clear write is issued.

Test Plan:
- Idle poll: POLL_DIV=4, enable=1, no edges -> RD_EDGE every 6 cycles (4 IDLE + RD_EDGE + WAIT_EDGE), address=3, write_n always 1, ev_valid stays 0.
- Single edge: in_port bit2 0->1, level 0x04, timestamp latched 0x0123 -> writedata=0x00000004 with write_n=0, then ev_data=0x01230404, ev_count=1.
- Partial clear: edges on bits0,1 already captured, bit5 edge arrives during RD_DATA -> first record mask=0x03, writedata=0x03. Next poll yields mask=0x20.
- Overflow: FIFO_DEPTH=2, ev_ready=0, three events -> ev_count=2, overflow=1, third record absent. Pulse overflow_clr -> overflow=0.
- Full with simultaneous pop: FIFO full, ev_ready=1 during PUSH -> new record enqueued, count stays 2, overflow stays 0.
- Reset/enable: reset_n low during WAIT_DATA -> chipselect=0, write_n=1, busy=0, FIFO empty. enable=0 during WR_CLR -> PUSH completes, then no further RD_EDGE.
